// File: rtl/bit_rate_pkg.sv
// Shared definitions for the bit-rate generator and the bit-rate meter.
//   RES_WIDTH     : width of the rate and statistics fields
//   state_e       : pacing FSM states (idle / run / drain)
//   ticks_per_sec : clock ticks in one second for a clock given in MHz
//   sat_inc       : saturating increment used by the statistics counters
package bit_rate_pkg;

  localparam int unsigned RES_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  function automatic int unsigned ticks_per_sec(input int unsigned clk_mhz);
    return clk_mhz * 1000000;
  endfunction

  function automatic logic [RES_WIDTH-1:0] sat_inc(input logic [RES_WIDTH-1:0] val,
                                                   input logic                 inc);
    if (inc && (val != '1)) begin
      return val + RES_WIDTH'(1);
    end
    return val;
  endfunction

endpackage

// File: rtl/bit_rate_gen_if.sv
// Control, handshake and statistics bundle of the bit-rate generator.
//   enable_i     : run request level
//   rate_i       : requested transfers per second
//   data_ready_i : consumer ready
//   data_valid_o : transfer offered
//   window_o     : pulse on the last tick of each one-second window
//   busy_o       : generator in run or drain
//   sent_cnt_o   : accepted transfers in the last completed window
//   drop_cnt_o   : dropped credits in the last completed window
// master: the generator side; slave: the controller/consumer side.
interface bit_rate_gen_if;
  import bit_rate_pkg::*;

  logic                 enable_i;
  logic [RES_WIDTH-1:0] rate_i;
  logic                 data_ready_i;
  logic                 data_valid_o;
  logic                 window_o;
  logic                 busy_o;
  logic [RES_WIDTH-1:0] sent_cnt_o;
  logic [RES_WIDTH-1:0] drop_cnt_o;

  modport master (
    input  enable_i,
    input  rate_i,
    input  data_ready_i,
    output data_valid_o,
    output window_o,
    output busy_o,
    output sent_cnt_o,
    output drop_cnt_o
  );

  modport slave (
    output enable_i,
    output rate_i,
    output data_ready_i,
    input  data_valid_o,
    input  window_o,
    input  busy_o,
    input  sent_cnt_o,
    input  drop_cnt_o
  );

endinterface

// File: rtl/rate_accumulator.sv
// Rate clamp and phase accumulator producing evenly spread credit strobes.
//   clk_i    : clock
//   rst_i    : asynchronous active-high reset
//   load_i   : capture clamped rate_i and clear the accumulator (start / window end)
//   run_i    : accumulate this cycle
//   rate_i   : requested transfers per second
//   credit_o : one credit generated this cycle (combinational, gated by run_i)
// Exactly `rate` credits fall in every window of TICKS_PER_SEC accumulating cycles and the
// accumulator lands back on zero at the window end.
module rate_accumulator
  import bit_rate_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 100000000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic                 run_i,
  input  logic [RES_WIDTH-1:0] rate_i,
  output logic                 credit_o
);

  localparam int unsigned AccW = $clog2(TICKS_PER_SEC) + 1;
  localparam logic [AccW:0] TicksSum = (AccW + 1)'(TICKS_PER_SEC);

  logic [AccW-1:0] acc_q, acc_d;
  logic [AccW-1:0] rate_q, rate_d;
  logic [AccW-1:0] rate_clamped;
  logic [AccW:0]   sum;

  // Clamp so that at most one credit can be produced per clock.
  assign rate_clamped = (rate_i > RES_WIDTH'(TICKS_PER_SEC)) ? AccW'(TICKS_PER_SEC)
                                                              : rate_i[AccW-1:0];

  // One extra bit keeps acc + rate (< 2 * TICKS_PER_SEC) from wrapping.
  assign sum      = {1'b0, acc_q} + {1'b0, rate_q};
  assign credit_o = run_i && (sum >= TicksSum);

  always_comb begin
    acc_d  = acc_q;
    rate_d = rate_q;
    if (load_i) begin
      acc_d  = '0;
      rate_d = rate_clamped;
    end else if (run_i) begin
      acc_d = credit_o ? AccW'(sum - TicksSum) : AccW'(sum);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q  <= '0;
      rate_q <= '0;
    end else begin
      acc_q  <= acc_d;
      rate_q <= rate_d;
    end
  end

endmodule

// File: rtl/bit_rate_gen.sv
// Paced traffic source: offers data_valid_o strobes at a programmed rate of N transfers per
// second, spread evenly across each one-second window, with a valid/ready handshake.
//   clk_i     : clock
//   s_rst_n_i : asynchronous reset, active HIGH despite the name
//   bus_io    : bit_rate_gen_if.master (enable, rate, ready in; valid, window, busy, stats out)
// Parameters: CLK_MHZ_VAL (clock in MHz), CREDIT_MAX (owed-transfer ceiling),
//   TICKS_PER_SEC (window length in clocks, derived from CLK_MHZ_VAL by default).
// Optional statistics: define BIT_RATE_GEN_STATS_EN to build the sent/drop counters;
// otherwise sent_cnt_o and drop_cnt_o are tied to zero.
module bit_rate_gen
  import bit_rate_pkg::*;
#(
  parameter int unsigned CLK_MHZ_VAL   = 100,
  parameter int unsigned CREDIT_MAX    = 15,
  parameter int unsigned TICKS_PER_SEC = ticks_per_sec(CLK_MHZ_VAL)
) (
  input  logic           clk_i,
  input  logic           s_rst_n_i,
  bit_rate_gen_if.master bus_io
);

  localparam int unsigned TickW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int unsigned CredW = $clog2(CREDIT_MAX + 1);
  localparam logic [TickW-1:0] TickLast  = TickW'(TICKS_PER_SEC - 1);
  localparam logic [CredW-1:0] CreditMax = CredW'(CREDIT_MAX);

  state_e           state_q, state_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [CredW-1:0] credit_q, credit_d;
  logic             valid_q, valid_d;

  logic start;
  logic window;
  logic acc_run;
  logic credit_gen;
  logic accept;

  rate_accumulator #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_rate_accumulator (
    .clk_i   (clk_i),
    .rst_i   (s_rst_n_i),
    .load_i  (start | window),
    .run_i   (acc_run),
    .rate_i  (bus_io.rate_i),
    .credit_o(credit_gen)
  );

  assign accept = valid_q & bus_io.data_ready_i;

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    credit_d = credit_q;
    start    = 1'b0;
    window   = 1'b0;
    acc_run  = 1'b0;
    unique case (state_q)
      StIdle: begin
        tick_d   = '0;
        credit_d = '0;
        if (bus_io.enable_i) begin
          start   = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_run = 1'b1;
        if (tick_q == TickLast) begin
          tick_d = '0;
          window = 1'b1;
        end else begin
          tick_d = tick_q + TickW'(1);
        end
        // Generate and accept together leave the credit unchanged; a credit arriving at
        // the ceiling with nothing leaving is dropped.
        if (credit_gen && !accept) begin
          if (credit_q != CreditMax) begin
            credit_d = credit_q + CredW'(1);
          end
        end else if (!credit_gen && accept) begin
          credit_d = credit_q - CredW'(1);
        end
        if (!bus_io.enable_i) begin
          state_d = (credit_d != '0) ? StDrain : StIdle;
        end
      end
      StDrain: begin
        // Only the offered transfer is completed; any remaining credit is discarded.
        if (accept) begin
          credit_d = '0;
          state_d  = StIdle;
        end
      end
      default: begin
        state_d  = StIdle;
        credit_d = '0;
        tick_d   = '0;
      end
    endcase
    valid_d = (credit_d != '0);
  end

  always_ff @(posedge clk_i or posedge s_rst_n_i) begin
    if (s_rst_n_i) begin
      state_q  <= StIdle;
      tick_q   <= '0;
      credit_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_d;
      credit_q <= credit_d;
      valid_q  <= valid_d;
    end
  end

  assign bus_io.data_valid_o = valid_q;
  assign bus_io.window_o     = window;
  assign bus_io.busy_o       = (state_q != StIdle);

`ifdef BIT_RATE_GEN_STATS_EN
  logic                 drop;
  logic [RES_WIDTH-1:0] sent_run_q, sent_run_d;
  logic [RES_WIDTH-1:0] drop_run_q, drop_run_d;
  logic [RES_WIDTH-1:0] sent_cnt_q, sent_cnt_d;
  logic [RES_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  // credit_gen is already gated to RUN, so this matches the dropped-credit case above.
  assign drop = credit_gen & ~accept & (credit_q == CreditMax);

  always_comb begin
    sent_run_d = sat_inc(sent_run_q, accept);
    drop_run_d = sat_inc(drop_run_q, drop);
    sent_cnt_d = sent_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (start) begin
      sent_run_d = '0;
      drop_run_d = '0;
    end else if (window) begin
      // Events in the window's last cycle belong to the window being closed.
      sent_cnt_d = sent_run_d;
      drop_cnt_d = drop_run_d;
      sent_run_d = '0;
      drop_run_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge s_rst_n_i) begin
    if (s_rst_n_i) begin
      sent_run_q <= '0;
      drop_run_q <= '0;
      sent_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      sent_run_q <= sent_run_d;
      drop_run_q <= drop_run_d;
      sent_cnt_q <= sent_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus_io.sent_cnt_o = sent_cnt_q;
  assign bus_io.drop_cnt_o = drop_cnt_q;
`else
  assign bus_io.sent_cnt_o = '0;
  assign bus_io.drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bit_rate_gen.sv
// Bench for bit_rate_gen with a 1000-tick window. The stimulus process pushes the expected
// per-window handshake count (and drop count) into a queue; the monitor counts handshakes
// and compares against the queue whenever window_o pulses.
module tb_bit_rate_gen;
  import bit_rate_pkg::*;

  localparam int unsigned T = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit_rate_gen_if bus ();

  bit_rate_gen #(
    .CLK_MHZ_VAL  (1),
    .CREDIT_MAX   (15),
    .TICKS_PER_SEC(T)
  ) dut (
    .clk_i    (clk),
    .s_rst_n_i(rst),
    .bus_io   (bus)
  );

  typedef struct {
    int sent;
    int drop;
  } win_t;

  win_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    int   hs_cnt;
    bit   stats_pend;
    win_t pend;
    win_t e;
    hs_cnt     = 0;
    stats_pend = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        hs_cnt     = 0;
        stats_pend = 1'b0;
        continue;
      end
      if (stats_pend) begin
`ifdef BIT_RATE_GEN_STATS_EN
        check("sent_cnt", longint'(bus.sent_cnt_o), longint'(pend.sent));
        check("drop_cnt", longint'(bus.drop_cnt_o), longint'(pend.drop));
`else
        check("sent_cnt_tied", longint'(bus.sent_cnt_o), 0);
        check("drop_cnt_tied", longint'(bus.drop_cnt_o), 0);
`endif
        stats_pend = 1'b0;
      end
      if (bus.data_valid_o && bus.data_ready_i) hs_cnt++;
      if (bus.window_o) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("window_handshakes", hs_cnt, e.sent);
          pend       = e;
          stats_pend = 1'b1;
        end
        hs_cnt = 0;
      end
    end
  end

  task automatic push_win(input int sent, input int drop);
    win_t w;
    w.sent = sent;
    w.drop = drop;
    exp_q.push_back(w);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst              = 1'b1;
    bus.enable_i     = 1'b0;
    bus.data_ready_i = 1'b0;
    bus.rate_i       = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Cycle 0 is the cycle in which enable_i is first sampled high.
  task automatic start(input logic [31:0] r, input logic rd);
    @(negedge clk);
    bus.rate_i       = r;
    bus.data_ready_i = rd;
    bus.enable_i     = 1'b1;
    cyc              = 0;
  endtask

  task automatic to(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int bad;
    bus.enable_i     = 1'b0;
    bus.data_ready_i = 1'b0;
    bus.rate_i       = '0;

    // Reset state.
    @(negedge clk);
    check("rst_valid", bus.data_valid_o, 0);
    check("rst_window", bus.window_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_sent", longint'(bus.sent_cnt_o), 0);
    check("rst_drop", longint'(bus.drop_cnt_o), 0);

    // Rate T/100: strobes 100 cycles apart; first window loses its last strobe to the next.
    do_reset();
    push_win(9, 0);
    push_win(10, 0);
    start(10, 1'b1);
    to(1);
    check("a_busy", bus.busy_o, 1);
    to(100);
    check("a_valid_c100", bus.data_valid_o, 0);
    to(101);
    check("a_valid_c101", bus.data_valid_o, 1);
    to(102);
    check("a_valid_c102", bus.data_valid_o, 0);
    to(200);
    check("a_valid_c200", bus.data_valid_o, 0);
    to(201);
    check("a_valid_c201", bus.data_valid_o, 1);
    to(999);
    check("a_window_c999", bus.window_o, 0);
    to(1000);
    check("a_window_c1000", bus.window_o, 1);
    to(1001);
    check("a_window_c1001", bus.window_o, 0);
    to(2005);

    // Over-range rate is clamped: valid continuous from cycle 2.
    do_reset();
    push_win(999, 0);
    push_win(1000, 0);
    start(2000, 1'b1);
    to(1);
    check("b_valid_c1", bus.data_valid_o, 0);
    bad = 0;
    for (int c = 2; c <= 2004; c++) begin
      to(c);
      if (bus.data_valid_o !== 1'b1) bad++;
    end
    check("b_valid_continuous", bad, 0);
    to(2005);

    // Rate T/2 with ready low for cycles 1..100: credit saturates, 35 credits dropped.
    do_reset();
    push_win(464, 35);
    start(500, 1'b0);
    to(2);
    check("c_valid_c2", bus.data_valid_o, 0);
    to(3);
    check("c_valid_c3", bus.data_valid_o, 1);
    to(100);
    check("c_valid_held", bus.data_valid_o, 1);
    to(101);
    bus.data_ready_i = 1'b1;
    to(1005);

    // Rate change mid-window takes effect at the next window.
    do_reset();
    push_win(9, 0);
    push_win(2, 0);
    push_win(2, 0);
    start(10, 1'b1);
    to(500);
    bus.rate_i = 2;
    to(3005);

    // Drain: enable drops with valid pending and ready low.
    do_reset();
    start(10, 1'b0);
    to(101);
    check("e_valid_c101", bus.data_valid_o, 1);
    to(150);
    bus.enable_i = 1'b0;
    for (int c = 151; c <= 155; c++) begin
      to(c);
      check("e_drain_valid", bus.data_valid_o, 1);
      check("e_drain_busy", bus.busy_o, 1);
    end
    to(156);
    check("e_valid_c156", bus.data_valid_o, 1);
    bus.data_ready_i = 1'b1;
    to(157);
    check("e_busy_c157", bus.busy_o, 0);
    check("e_valid_c157", bus.data_valid_o, 0);

    // Reset mid-run, then restart.
    do_reset();
    start(T, 1'b1);
    to(10);
    check("f_valid_c10", bus.data_valid_o, 1);
    #2;
    rst          = 1'b1;
    bus.enable_i = 1'b0;
    #1;
    check("f_rst_valid", bus.data_valid_o, 0);
    check("f_rst_busy", bus.busy_o, 0);
    check("f_rst_window", bus.window_o, 0);
    @(negedge clk);
    rst = 1'b0;
    start(T, 1'b1);
    to(1);
    check("f_restart_valid_c1", bus.data_valid_o, 0);
    check("f_restart_busy_c1", bus.busy_o, 1);
    to(2);
    check("f_restart_valid_c2", bus.data_valid_o, 1);

    // Rate 0: windows tick, no strobes.
    do_reset();
    push_win(0, 0);
    start(0, 1'b1);
    to(500);
    check("g_valid_c500", bus.data_valid_o, 0);
    to(1005);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_rate_gen.md
# bit_rate_gen

- Paced traffic source: emits `data_valid_o` strobes at a programmed rate of N transfers per second, spread evenly over each one-second window.
- It is the stimulus-side counterpart of the bit-rate meter. It drives the same `data_valid` stream the meter measures, with a valid/ready handshake toward the consumer.
- Used for link loading and for closed-loop self-test of the meter.

## Interface
Parameters:
- `CLK_MHZ_VAL`, 100: clock frequency in MHz. TICKS_PER_SEC = CLK_MHZ_VAL * 1000000.
- `CREDIT_MAX`, 15: maximum count of owed, not-yet-accepted transfers.
- `RES_WIDTH`, 32 (localparam): width of the rate and statistics fields.

Ports:
- `clk_i` input 1: the single clock.
- `s_rst_n_i` input 1: reset. Asynchronous assertion, active-high.
- `enable_i` input 1: level. 1 = generate, 0 = stop after draining.
- `rate_i` input RES_WIDTH: requested transfers per second. Sampled only at start or at a window boundary.
- `data_ready_i` input 1: consumer ready.
- `data_valid_o` output 1: transfer offered. Reset 0.
- `window_o` output 1: one-cycle pulse on the last tick of each window. Reset 0.
- `busy_o` output 1: 1 in RUN or DRAIN. Reset 0.
- `sent_cnt_o` output RES_WIDTH: statistics only; see Configuration. Reset 0.
- `drop_cnt_o` output RES_WIDTH: statistics only; see Configuration. Reset 0.

## Operation
State machine:
- IDLE: all counters zero, `data_valid_o` = 0. When `enable_i` = 1: load the rate, clear the tick counter, accumulator and credit, then go to RUN.
- RUN: accumulation and pacing are active.
  - `enable_i` = 0 with credit > 0 or a transfer pending: go to DRAIN.
  - `enable_i` = 0 otherwise: go to IDLE.
- DRAIN: no new credits are generated. The transfer in flight is held until accepted, then the FSM goes to IDLE and credit is discarded.

Rate handling:
- Effective rate = min(`rate_i`, TICKS_PER_SEC), so at most one credit per clock.
- Accumulator: width $clog2(TICKS_PER_SEC)+1, evaluated every RUN cycle.
  - If acc + rate >= TICKS_PER_SEC: acc <= acc + rate - TICKS_PER_SEC and a credit is generated.
  - Otherwise: acc <= acc + rate.
- Exactly `rate` credits are generated per window, and acc returns to 0 at the window end.
- Tick counter runs 0 .. TICKS_PER_SEC-1. On the last tick it wraps, `window_o` pulses, rate is reloaded from `rate_i` and acc is cleared.

Credit and handshake:
- `data_valid_o` = (credit != 0). A transfer completes on `data_valid_o` & `data_ready_i`.
- A credit generated and a transfer completed in the same cycle leave the credit unchanged.
- A credit generated while credit == CREDIT_MAX is dropped. Credit saturates and does not wrap.
- Once `data_valid_o` is 1 it stays 1 until the transfer is accepted, including through a RUN -> DRAIN transition.
- Rate 0: no credits, `data_valid_o` stays 0, windows still tick.

Reset mid-operation: all state returns to IDLE/zero immediately, asynchronously. A pending valid is abandoned.

## Timing
- `data_valid_o` is a registered output.
- `enable_i` sampled high in cycle 0 -> RUN in cycle 1 -> first credit evaluated in cycle 1 -> earliest `data_valid_o` in cycle 2.
- With rate = TICKS_PER_SEC and `data_ready_i` held 1: `data_valid_o` is continuously 1 from cycle 2.
- With rate = TICKS_PER_SEC/K (K an integer): strobes are spaced exactly K cycles apart.
- `window_o` is asserted in the cycle where tick = TICKS_PER_SEC-1. The new rate takes effect on the next tick.
- `busy_o` deasserts in the cycle after the last DRAIN handshake.

## Configuration
- Macro `BIT_RATE_GEN_STATS_EN`.
- Defined: `sent_cnt_o` holds the number of accepted transfers in the last completed window; `drop_cnt_o` holds the number of dropped credits in that window. Both update at `window_o` and saturate at all-ones.
- Undefined: both ports are driven constant 0 and their counters are not synthesized. Pacing behaviour is identical.

## Structure
- Shared package `bit_rate_pkg`:
  - RES_WIDTH.
  - State enum (IDLE, RUN, DRAIN).
  - Function `ticks_per_sec(clk_mhz)`.
  - This package is shared with the meter.
- One sub-module, `rate_accumulator`: rate clamp, accumulator and the credit-strobe output.

## Test plan
- CLK_MHZ_VAL=1, rate_i=1000, ready=1: exactly 1000 strobes per window, 1000 cycles apart; `sent_cnt_o`=1000.
- rate_i=2000000 (over range), ready=1: rate is clamped, `data_valid_o` is constant 1, 1000000 per window.
- rate_i=500000, ready=0 for 100 cycles then 1: valid is held and credit saturates at 15; `drop_cnt_o`=35 at window end (with STATS).
- Change rate_i from 1000 to 10 mid-window: the current window still yields 1000; the next window yields 10.
- Drop `enable_i` while valid=1 and ready=0 for 5 cycles: valid is held, the handshake completes, then IDLE; `busy_o` falls the following cycle.
- Assert reset mid-RUN: all outputs are 0 in the same cycle; re-enabling restarts with the first strobe no earlier than cycle 2.
